// File: rtl/nes_mem_arbiter.sv
// Arbiter for the shared cartridge memory port: PPU CHR, CPU PRG/WRAM and loader.
// Fixed priority with a loader starvation guard, one outstanding transaction, watchdog abort.
module nes_mem_arbiter #(
    parameter int unsigned ADDR_W     = 22,
    parameter int unsigned STARVE_MAX = 8,
    parameter int unsigned TIMEOUT    = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        req_i,
    input  logic [ADDR_W-1:0] addr0_i,
    input  logic [ADDR_W-1:0] addr1_i,
    input  logic [ADDR_W-1:0] addr2_i,
    input  logic [2:0]        we_i,
    input  logic [7:0]        wdata0_i,
    input  logic [7:0]        wdata1_i,
    input  logic [7:0]        wdata2_i,
    output logic [2:0]        ack_o,
    output logic [7:0]        rdata_o,
    output logic              err_o,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_we_o,
    output logic [7:0]        mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [7:0]        mem_rdata_i
);

    localparam int unsigned SW = $clog2(STARVE_MAX + 1);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [1:0]        gnt_q, gnt_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic [TW-1:0]     wdog_q, wdog_d;
    logic              mem_req_q, mem_req_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_we_q, mem_we_d;
    logic [7:0]        mem_wdata_q, mem_wdata_d;
    logic [7:0]        rdata_q, rdata_d;
    logic [2:0]        ack_q, ack_d;
    logic              err_q, err_d;
    logic [1:0]        win;

    // Loader overrides the fixed 0 > 1 > 2 order once it has lost STARVE_MAX times in a row
    always_comb begin
        win = 2'd2;
        if (req_i[2] && (starve_q == SW'(STARVE_MAX))) begin
            win = 2'd2;
        end else if (req_i[0]) begin
            win = 2'd0;
        end else if (req_i[1]) begin
            win = 2'd1;
        end
    end

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        starve_d    = starve_q;
        wdog_d      = wdog_q;
        mem_req_d   = mem_req_q;
        mem_addr_d  = mem_addr_q;
        mem_we_d    = mem_we_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        ack_d       = 3'b000;
        err_d       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!req_i[2]) begin
                    starve_d = '0;
                end
                if (|req_i) begin
                    gnt_d     = win;
                    mem_req_d = 1'b1;
                    wdog_d    = '0;
                    state_d   = S_BUSY;
                    case (win)
                        2'd0: begin
                            mem_addr_d  = addr0_i;
                            mem_we_d    = we_i[0];
                            mem_wdata_d = wdata0_i;
                        end
                        2'd1: begin
                            mem_addr_d  = addr1_i;
                            mem_we_d    = we_i[1];
                            mem_wdata_d = wdata1_i;
                        end
                        default: begin
                            mem_addr_d  = addr2_i;
                            mem_we_d    = we_i[2];
                            mem_wdata_d = wdata2_i;
                        end
                    endcase
                    if (win == 2'd2) begin
                        starve_d = '0;
                    end else if (req_i[2] && (starve_q != SW'(STARVE_MAX))) begin
                        starve_d = starve_q + SW'(1);
                    end
                end
            end
            S_BUSY: begin
                // A memory ack in the expiry cycle takes precedence over the abort
                if (mem_ack_i) begin
                    rdata_d   = mem_rdata_i;
                    mem_req_d = 1'b0;
                    ack_d     = 3'b001 << gnt_q;
                    state_d   = S_DONE;
                end else if (wdog_q == TW'(TIMEOUT - 1)) begin
                    rdata_d   = 8'hFF;
                    err_d     = 1'b1;
                    mem_req_d = 1'b0;
                    ack_d     = 3'b001 << gnt_q;
                    state_d   = S_DONE;
                end else begin
                    wdog_d = wdog_q + TW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            gnt_q       <= 2'd0;
            starve_q    <= '0;
            wdog_q      <= '0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= 8'h00;
            rdata_q     <= 8'h00;
            ack_q       <= 3'b000;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            starve_q    <= starve_d;
            wdog_q      <= wdog_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
        end
    end

    assign ack_o       = ack_q;
    assign err_o       = err_q;
    assign rdata_o     = rdata_q;
    assign mem_req_o   = mem_req_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_we_o    = mem_we_q;
    assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_nes_mem_arbiter.sv
// Scoreboard bench for nes_mem_arbiter: transaction-level reference model, memory responder,
// and a monitor that checks grants and completions as the DUT presents them.
module tb_nes_mem_arbiter;

    localparam int unsigned ADDR_W     = 22;
    localparam int unsigned STARVE_MAX = 8;
    localparam int unsigned TIMEOUT    = 64;

    logic              clk = 1'b0;
    logic              reset;
    logic [2:0]        req;
    logic [ADDR_W-1:0] addr_a [3];
    logic [2:0]        we;
    logic [7:0]        wdata_a [3];
    logic [2:0]        ack;
    logic [7:0]        rdata;
    logic              err;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [7:0]        mem_wdata;
    logic              mem_ack;
    logic [7:0]        mem_rdata;

    always #5 clk = ~clk;

    nes_mem_arbiter #(.ADDR_W(ADDR_W), .STARVE_MAX(STARVE_MAX), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .req_i(req),
        .addr0_i(addr_a[0]), .addr1_i(addr_a[1]), .addr2_i(addr_a[2]),
        .we_i(we), .wdata0_i(wdata_a[0]), .wdata1_i(wdata_a[1]), .wdata2_i(wdata_a[2]),
        .ack_o(ack), .rdata_o(rdata), .err_o(err),
        .mem_req_o(mem_req), .mem_addr_o(mem_addr), .mem_we_o(mem_we), .mem_wdata_o(mem_wdata),
        .mem_ack_i(mem_ack), .mem_rdata_i(mem_rdata)
    );

    typedef struct {
        int                port;
        logic [ADDR_W-1:0] addr;
        logic              we;
        logic [7:0]        wdata;
        int                due;
    } grant_t;

    typedef struct {
        int        port;
        logic [7:0] rdata;
        logic      err;
        int        due;
    } done_t;

    grant_t gq[$];
    done_t  dq[$];
    int     ack_log[$];

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state (written only by the model process)
    int cyc, m_phase, m_port, m_bcnt, m_starve;
    // monitor observations
    int   last_grant_cyc, last_ack_cyc;
    logic last_err;
    logic prev_req;
    grant_t cur;
    // stimulus knobs (written only by the main process)
    int       prob [3];
    logic [2:0] keep, hold_off;
    logic     drop_en;
    int       fix_lat;
    logic [7:0] fix_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: one transaction at a time, IDLE -> BUSY (count cycles) -> DONE
    initial begin
        cyc = 0; m_phase = 0; m_port = 0; m_bcnt = 0; m_starve = 0;
        forever begin
            @(posedge clk);
            cyc++;
            if (reset) begin
                m_phase = 0;
                m_starve = 0;
                gq.delete();
                dq.delete();
            end else if (m_phase == 0) begin
                if (!req[2]) m_starve = 0;
                if (req != 3'b000) begin
                    grant_t g;
                    if (req[2] && m_starve == int'(STARVE_MAX)) m_port = 2;
                    else if (req[0]) m_port = 0;
                    else if (req[1]) m_port = 1;
                    else m_port = 2;
                    if (m_port == 2) m_starve = 0;
                    else if (req[2]) m_starve = (m_starve < int'(STARVE_MAX)) ? m_starve + 1 : int'(STARVE_MAX);
                    g.port = m_port; g.addr = addr_a[m_port]; g.we = we[m_port];
                    g.wdata = wdata_a[m_port]; g.due = cyc;
                    gq.push_back(g);
                    m_phase = 1;
                    m_bcnt = 0;
                end
            end else if (m_phase == 1) begin
                done_t d;
                m_bcnt++;
                d.port = m_port; d.due = cyc;
                if (mem_ack) begin
                    d.rdata = mem_rdata; d.err = 1'b0;
                    dq.push_back(d);
                    m_phase = 2;
                end else if (m_bcnt == int'(TIMEOUT)) begin
                    d.rdata = 8'hFF; d.err = 1'b1;
                    dq.push_back(d);
                    m_phase = 2;
                end
            end else begin
                m_phase = 0;
            end
        end
    end

    function automatic int pick_lat();
        int r;
        if (fix_lat != 0) return fix_lat;
        r = int'($urandom_range(0, 19));
        if (r == 0) return 1000;
        if (r == 1) return int'(TIMEOUT);
        return int'($urandom_range(1, 6));
    endfunction

    // Memory responder: acks after a chosen number of BUSY cycles, plus stray acks while idle
    initial begin
        int k, lat;
        k = 0; lat = 1; mem_ack = 1'b0; mem_rdata = 8'h00;
        forever begin
            @(negedge clk);
            mem_ack = 1'b0;
            mem_rdata = 8'($urandom);
            if (mem_req) begin
                if (k == 0) lat = pick_lat();
                k++;
                if (k == lat) begin
                    mem_ack = 1'b1;
                    if (fix_lat != 0) mem_rdata = fix_data;
                end
            end else begin
                k = 0;
                if ($urandom_range(0, 7) == 0) mem_ack = 1'b1;
            end
        end
    end

    // Monitor: pops expectations whenever the DUT grants or completes
    initial begin
        grant_t g;
        done_t  d;
        prev_req = 1'b0; last_err = 1'b0; last_grant_cyc = 0; last_ack_cyc = 0;
        forever begin
            @(negedge clk);
            check("mem_req_level", 32'(mem_req), (m_phase == 1) ? 32'd1 : 32'd0);
            if (mem_req && !prev_req) begin
                n_checks++;
                if (gq.size() == 0) begin
                    n_fail++;
                    $display("FAIL grant_unexpected: mem_req rose at cycle %0d with none expected", cyc);
                end else begin
                    g = gq.pop_front();
                    cur = g;
                    last_grant_cyc = cyc;
                    check("grant_cycle", cyc, g.due);
                    check("mem_addr", 32'(mem_addr), 32'(g.addr));
                    check("mem_we", 32'(mem_we), 32'(g.we));
                    check("mem_wdata", 32'(mem_wdata), 32'(g.wdata));
                end
            end else if (mem_req) begin
                check("mem_addr_stable", 32'(mem_addr), 32'(cur.addr));
                check("mem_we_stable", 32'(mem_we), 32'(cur.we));
                check("mem_wdata_stable", 32'(mem_wdata), 32'(cur.wdata));
            end
            if (ack != 3'b000) begin
                check("ack_onehot", $countones(ack), 32'd1);
                for (int p = 0; p < 3; p++) if (ack[p]) ack_log.push_back(p);
                last_err = err;
                last_ack_cyc = cyc;
                n_checks++;
                if (dq.size() == 0) begin
                    n_fail++;
                    $display("FAIL ack_unexpected: ack=%b at cycle %0d with none expected", ack, cyc);
                end else begin
                    d = dq.pop_front();
                    check("ack_port", 32'(ack), 32'(1) << d.port);
                    check("ack_cycle", cyc, d.due);
                    check("rdata", 32'(rdata), 32'(d.rdata));
                    check("err", 32'(err), 32'(d.err));
                end
            end else begin
                check("err_without_ack", 32'(err), 32'd0);
            end
            if (gq.size() > 0 && gq[0].due < cyc) begin
                n_checks++; n_fail++;
                $display("FAIL grant_missing: expected at cycle %0d, now %0d", gq[0].due, cyc);
                void'(gq.pop_front());
            end
            if (dq.size() > 0 && dq[0].due < cyc) begin
                n_checks++; n_fail++;
                $display("FAIL ack_missing: expected at cycle %0d, now %0d", dq[0].due, cyc);
                void'(dq.pop_front());
            end
            prev_req = mem_req;
        end
    end

    task automatic set_payload(input int p, input logic [ADDR_W-1:0] a, input logic w, input logic [7:0] d);
        addr_a[p] = a;
        we[p] = w;
        wdata_a[p] = d;
    endtask

    // One cycle of requester behaviour: drop or renew on ack, random new requests, rare drop while granted
    task automatic step();
        @(negedge clk);
        for (int p = 0; p < 3; p++) begin
            if (ack[p]) begin
                hold_off[p] = 1'b0;
                if (keep[p]) set_payload(p, ADDR_W'($urandom), 1'($urandom), 8'($urandom));
                req[p] = keep[p];
            end else if (!req[p] && !hold_off[p] && int'($urandom_range(0, 99)) < prob[p]) begin
                set_payload(p, ADDR_W'($urandom), 1'($urandom), 8'($urandom));
                req[p] = 1'b1;
            end else if (drop_en && req[p] && m_phase == 1 && m_port == p && $urandom_range(0, 15) == 0) begin
                req[p] = 1'b0;
                hold_off[p] = 1'b1;
            end
        end
    endtask

    task automatic wait_idle(input string name, input int max);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < max && !ok; i++) begin
            step();
            if (req == 3'b000 && m_phase == 0 && gq.size() == 0 && dq.size() == 0) ok = 1'b1;
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: not idle after %0d cycles", name, max);
        end
    endtask

    task automatic wait_acks(input string name, input int n, input int max);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < max && !ok; i++) begin
            step();
            if (ack_log.size() >= n) ok = 1'b1;
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: only %0d acks after %0d cycles", name, ack_log.size(), max);
        end
    endtask

    initial begin
        #600000;
        n_fail++;
        $display("FAIL global_timeout: bench did not complete at cycle %0d", cyc);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        int base;
        bit hit;
        reset = 1'b1; req = 3'b000; we = 3'b000;
        keep = 3'b000; hold_off = 3'b000; drop_en = 1'b0;
        fix_lat = 2; fix_data = 8'h00;
        for (int p = 0; p < 3; p++) begin
            prob[p] = 0;
            addr_a[p] = '0;
            wdata_a[p] = 8'h00;
        end
        repeat (3) @(negedge clk);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_rdata", 32'(rdata), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        reset = 1'b0;

        // single port 1 read, memory answers on the second BUSY cycle
        step();
        base = ack_log.size();
        fix_lat = 2; fix_data = 8'h5A;
        set_payload(1, 22'h12345, 1'b0, 8'h00);
        req[1] = 1'b1;
        wait_idle("t1_idle", 100);
        check("t1_rdata", 32'(rdata), 32'h5A);
        check("t1_ack_count", ack_log.size() - base, 32'd1);
        check("t1_latency", last_ack_cyc - last_grant_cyc, 32'd2);

        // simultaneous requests complete in priority order
        base = ack_log.size();
        fix_lat = 1;
        for (int p = 0; p < 3; p++) set_payload(p, ADDR_W'($urandom), 1'b0, 8'($urandom));
        req = 3'b111;
        wait_idle("t2_idle", 100);
        check("t2_ack_count", ack_log.size() - base, 32'd3);
        for (int i = 0; i < 3; i++) check("t2_order", (ack_log.size() > base + i) ? ack_log[base + i] : -1, i);

        // loader starvation guard with ports 0 and 2 requesting continuously
        base = ack_log.size();
        fix_lat = 2; keep = 3'b101;
        set_payload(0, ADDR_W'($urandom), 1'b0, 8'h00);
        set_payload(2, ADDR_W'($urandom), 1'b1, 8'($urandom));
        req = 3'b101;
        wait_acks("t3_acks", base + 18, 400);
        keep = 3'b000;
        wait_idle("t3_idle", 200);
        for (int i = 0; i < 18; i++)
            check("t3_starve_order", (ack_log.size() > base + i) ? ack_log[base + i] : -1,
                  (i == int'(STARVE_MAX) || i == 2 * int'(STARVE_MAX) + 1) ? 2 : 0);

        // loader write at the top of the address space, payload held through BUSY
        fix_lat = 5;
        set_payload(2, 22'h3FFFFF, 1'b1, 8'hC3);
        req[2] = 1'b1;
        repeat (3) step();
        check("t4_mem_addr", 32'(mem_addr), 32'h3FFFFF);
        check("t4_mem_we", 32'(mem_we), 32'd1);
        check("t4_mem_wdata", 32'(mem_wdata), 32'hC3);
        check("t4_mem_req", 32'(mem_req), 32'd1);
        wait_idle("t4_idle", 100);

        // watchdog abort, then an ack on exactly the last BUSY cycle
        fix_lat = 1000;
        set_payload(1, ADDR_W'($urandom), 1'b0, 8'h00);
        req[1] = 1'b1;
        wait_idle("t5_idle", 200);
        check("t5_err", 32'(last_err), 32'd1);
        check("t5_rdata", 32'(rdata), 32'hFF);
        check("t5_span", last_ack_cyc - last_grant_cyc, TIMEOUT);
        fix_lat = int'(TIMEOUT); fix_data = 8'h3C;
        set_payload(1, ADDR_W'($urandom), 1'b0, 8'h00);
        req[1] = 1'b1;
        wait_idle("t5b_idle", 200);
        check("t5b_err", 32'(last_err), 32'd0);
        check("t5b_rdata", 32'(rdata), 32'h3C);
        check("t5b_span", last_ack_cyc - last_grant_cyc, TIMEOUT);

        // reset in the middle of a transaction abandons it; the held request is then served
        fix_lat = 1000;
        base = ack_log.size();
        set_payload(0, ADDR_W'($urandom), 1'b0, 8'h00);
        req[0] = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            step();
            if (mem_req) hit = 1'b1;
        end
        check("t6_granted", 32'(hit), 32'd1);
        repeat (4) step();
        reset = 1'b1;
        @(negedge clk);
        check("t6_mem_req_drop", 32'(mem_req), 32'd0);
        check("t6_no_ack", 32'(ack), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        fix_lat = 3;
        wait_idle("t6_idle", 100);
        check("t6_ack_count", ack_log.size() - base, 32'd1);
        check("t6_ack_port", (ack_log.size() > base) ? ack_log[base] : -1, 32'd0);

        // randomized traffic
        base = ack_log.size();
        fix_lat = 0; drop_en = 1'b1;
        prob[0] = 30; prob[1] = 30; prob[2] = 20;
        for (int i = 0; i < 4000; i++) begin
            if (i % 250 == 0) keep = 3'($urandom);
            step();
        end
        prob[0] = 0; prob[1] = 0; prob[2] = 0;
        keep = 3'b000; drop_en = 1'b0;
        wait_idle("rand_idle", 3000);
        check("rand_activity", (ack_log.size() - base > 50) ? 32'd1 : 32'd0, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
